nbbpu_loader: RTL
=================

# nbbpu_loader

Serial program loader sitting directly upstream of the NBBPU instruction memory. It receives a framed program over a UART line (8N1), writes each 16-bit instruction word into the program RAM through a single-cycle write port, and holds the NBBPU in reset until a complete frame with a valid checksum has been loaded. It replaces the fixed ROM image during bring-up, so new programs run without resynthesis.

## Interface
- `CLKS_PER_BIT`, 104: clock cycles per UART bit (12 MHz / 115200); must be ≥ 4.
- `clock`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `rx`  in  1  UART serial input; idle high; asynchronous to `clock`.
- `prog_write`  out  1  one-cycle write strobe to the program RAM.
- `prog_address`  out  16  program RAM word address.
- `prog_data`  out  16  instruction word to write.
- `cpu_reset`  out  1  active-high reset to the NBBPU; 1 = CPU held.
- `busy`  out  1  1 while a frame is in progress (header accepted, checksum not yet checked).
- `error`  out  1  sticky flag: last frame failed (checksum or framing); cleared when a header byte is accepted.

## Operation
- `rx` passes through a 2-flop synchronizer before any use.
- UART receiver:
  - Idle until the synchronized `rx` is low.
  - Waits `CLKS_PER_BIT/2` cycles and re-samples. If `rx` is high, this is a glitch: return to idle with no error.
  - Samples 8 data bits (LSB first) at `CLKS_PER_BIT` intervals, then samples the stop bit.
  - Stop bit = 1 produces a one-cycle internal `byte_valid`. Stop bit = 0 is a framing error.
- Frame format: header `0xA5`, then count byte N (0..255 words), then N words sent high byte first, then a checksum byte. The checksum is the XOR of all 2N data bytes (0x00 when N = 0).
- Frame FSM states: WAIT_HEADER, GET_COUNT, GET_HIGH, GET_LOW, GET_CHECK.
  - WAIT_HEADER: any byte other than `0xA5` is ignored. On `0xA5`: `cpu_reset`←1, `busy`←1, `error`←0, word index←0, checksum←0, go to GET_COUNT.
  - GET_COUNT: latch N. Go to GET_CHECK if N = 0, otherwise to GET_HIGH.
  - GET_HIGH: latch the high byte and XOR it into the checksum. Go to GET_LOW.
  - GET_LOW: XOR the low byte into the checksum. Next cycle: `prog_data` = {high, low}, `prog_address` = word index, `prog_write` = 1. Then increment the index. Go to GET_CHECK when the index reaches N, else to GET_HIGH.
  - GET_CHECK: if the byte matches the running checksum, `cpu_reset`←0. If it mismatches, `error`←1 and `cpu_reset` stays 1. In both cases `busy`←0 and go to WAIT_HEADER.
- A framing error in any state sets `error`←1, `busy`←0, keeps `cpu_reset`=1 and returns to WAIT_HEADER.
- Words are written as they arrive, before the checksum is verified. The CPU only runs after verification.
- Word index is 8 bits (max 255 words). `prog_address` = {8'h00, index}.
- A header arriving while the CPU runs (`cpu_reset`=0) re-asserts `cpu_reset` and starts a new load.

## Timing
- Reset values: `prog_write`=0, `prog_address`=0, `prog_data`=0, `cpu_reset`=1, `busy`=0, `error`=0. FSM in WAIT_HEADER, receiver idle.
- Reset mid-frame aborts immediately: the same values apply and no further writes occur.
- `byte_valid` fires at the stop-bit mid-sample, 2 + 9.5×`CLKS_PER_BIT` (±1) cycles after the falling edge of `rx`.
- `prog_write` is high for exactly one cycle, the cycle after the low byte's `byte_valid`. `prog_address` and `prog_data` are valid in that same cycle and hold until the next write.
- `cpu_reset` falls, and `busy` falls, one cycle after the checksum byte's `byte_valid`.
- `cpu_reset` and `busy` rise one cycle after the header's `byte_valid`.
- At most one byte is in flight, so FSM/receiver overlap cannot occur. The receiver may start the next byte during the cycle of `byte_valid`.

## Test plan
- Reset: hold `reset`=0 with `rx` toggling → all outputs at reset values, no `prog_write`; release → still `cpu_reset`=1, `busy`=0.
- Valid frame `A5 02 12 34 AB CD 40`:
  - → exactly two `prog_write` pulses: address 0 → `0x1234`, address 1 → `0xABCD`.
  - → then `cpu_reset`=0, `busy`=0, `error`=0.
- Bad checksum `A5 02 12 34 AB CD 41` → two writes still occur; `error`=1, `cpu_reset` stays 1. A following valid frame clears `error` and releases `cpu_reset`.
- Garbage and glitches:
  - Bytes `00 FF 5A` before a valid frame → ignored.
  - A low pulse of `CLKS_PER_BIT/4` on `rx` → no byte, no error.
  - The frame that follows loads normally.
- Framing error: stop bit driven low on the count byte → `error`=1, `busy`=0, no writes. The next `A5 00 00` → `error`=0, `cpu_reset`=0, no writes.
- Reset mid-frame: assert `reset` after the first word's write of `A5 03 ...` → outputs return to reset values at once, no further writes. After release, a full valid frame loads from address 0.

Source files
------------

// File: rtl/nbbpu_loader_if.sv
// Program RAM write port between the serial loader (master) and the NBBPU
// instruction memory (slave).
interface nbbpu_loader_if;
  logic        prog_write;
  logic [15:0] prog_address;
  logic [15:0] prog_data;

  modport master (output prog_write, prog_address, prog_data);
  modport slave  (input  prog_write, prog_address, prog_data);
endinterface

// File: rtl/nbbpu_loader.sv
// UART (8N1) program loader for the NBBPU: parses A5/count/words/checksum frames,
// writes words to program RAM and releases the CPU only after a good checksum.
module nbbpu_loader #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           rx,
  nbbpu_loader_if.master prog,
  output logic           cpu_reset,
  output logic           busy,
  output logic           error
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {WAIT_HEADER, GET_COUNT, GET_HIGH, GET_LOW, GET_CHECK} frame_state_t;

  rx_state_t    rx_state, rx_next;
  frame_state_t state, state_next;

  logic          rx_meta, rx_sync;
  logic [CW-1:0] clk_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    rx_shift;
  logic          cnt_full, cnt_half, byte_valid, frame_err;
  logic [7:0]    word_count, word_index, high_byte, checksum;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  assign cnt_full   = (clk_cnt == FULL_LAST);
  assign cnt_half   = (clk_cnt == HALF_LAST);
  assign byte_valid = (rx_state == RX_STOP) && cnt_full && rx_sync;
  assign frame_err  = (rx_state == RX_STOP) && cnt_full && !rx_sync;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) rx_state <= RX_IDLE;
    else        rx_state <= rx_next;
  end

  // A start bit that is high again at its midpoint was a glitch: drop it silently.
  always_comb begin
    rx_next = rx_state;
    unique case (rx_state)
      RX_IDLE:  if (!rx_sync) rx_next = RX_START;
      RX_START: if (cnt_half) rx_next = rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (cnt_full && bit_idx == 3'd7) rx_next = RX_STOP;
      RX_STOP:  if (cnt_full) rx_next = RX_IDLE;
      default:  rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      clk_cnt  <= '0;
      bit_idx  <= 3'd0;
      rx_shift <= 8'h00;
    end else begin
      if (rx_state == RX_IDLE || rx_next != rx_state || cnt_full) clk_cnt <= '0;
      else                                                        clk_cnt <= clk_cnt + 1'b1;
      if (rx_state == RX_START) bit_idx <= 3'd0;
      if (rx_state == RX_DATA && cnt_full) begin
        rx_shift <= {rx_sync, rx_shift[7:1]};
        bit_idx  <= bit_idx + 3'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= WAIT_HEADER;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (frame_err) begin
      state_next = WAIT_HEADER;
    end else if (byte_valid) begin
      unique case (state)
        WAIT_HEADER: if (rx_shift == 8'hA5) state_next = GET_COUNT;
        GET_COUNT:   state_next = (rx_shift == 8'h00) ? GET_CHECK : GET_HIGH;
        GET_HIGH:    state_next = GET_LOW;
        GET_LOW:     state_next = (word_index + 8'd1 == word_count) ? GET_CHECK : GET_HIGH;
        GET_CHECK:   state_next = WAIT_HEADER;
        default:     state_next = WAIT_HEADER;
      endcase
    end
  end

  // Words go to RAM as they arrive; only a matching checksum lets the CPU run.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prog.prog_write   <= 1'b0;
      prog.prog_address <= 16'h0000;
      prog.prog_data    <= 16'h0000;
      cpu_reset         <= 1'b1;
      busy              <= 1'b0;
      error             <= 1'b0;
      word_count        <= 8'h00;
      word_index        <= 8'h00;
      high_byte         <= 8'h00;
      checksum          <= 8'h00;
    end else begin
      prog.prog_write <= 1'b0;
      if (frame_err) begin
        error <= 1'b1;
        busy  <= 1'b0;
      end else if (byte_valid) begin
        unique case (state)
          WAIT_HEADER: if (rx_shift == 8'hA5) begin
            cpu_reset  <= 1'b1;
            busy       <= 1'b1;
            error      <= 1'b0;
            word_index <= 8'h00;
            checksum   <= 8'h00;
          end
          GET_COUNT: word_count <= rx_shift;
          GET_HIGH: begin
            high_byte <= rx_shift;
            checksum  <= checksum ^ rx_shift;
          end
          GET_LOW: begin
            checksum          <= checksum ^ rx_shift;
            prog.prog_write   <= 1'b1;
            prog.prog_address <= {8'h00, word_index};
            prog.prog_data    <= {high_byte, rx_shift};
            word_index        <= word_index + 8'd1;
          end
          GET_CHECK: begin
            if (rx_shift == checksum) cpu_reset <= 1'b0;
            else                      error     <= 1'b1;
            busy <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end
endmodule
